// File: rtl/icache_2way_if.sv
// Fetch-side and memory-side bundle for the two-way instruction cache.
// The cache plays the slave role; the fetch stage/memory model plays master.
interface icache_2way_if #(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 16
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);

  logic                             cpu_req;
  logic [ADDR_W-1:0]                cpu_addr;
  logic                             flush;
  logic [WORD_W-1:0]                cpu_instr;
  logic                             cpu_valid;
  logic                             busy;
  logic                             mem_req;
  logic [ADDR_W-OFF_W-1:0]          mem_addr;
  logic                             mem_valid;
  logic [WORD_W*WORDS_PER_LINE-1:0] mem_line;
  logic [CNT_W-1:0]                 hit_cnt;
  logic [CNT_W-1:0]                 miss_cnt;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_valid, mem_line,
    output cpu_instr, cpu_valid, busy, mem_req, mem_addr, hit_cnt, miss_cnt
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_valid, mem_line,
    input  cpu_instr, cpu_valid, busy, mem_req, mem_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with true-LRU replacement,
// a blocking miss/refill FSM, whole-cache flush and saturating hit/miss counters.
module icache_2way #(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int SETS           = 32,
  parameter int CNT_W          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  icache_2way_if.slave  bus
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t                     r_state, w_state_nx;
  logic [1:0][SETS-1:0]       r_valid;
  logic [SETS-1:0]            r_lru;      // names the least-recently-used way
  logic [TAG_W-1:0]           r_tag  [2][SETS];
  logic [LINE_W-1:0]          r_data [2][SETS];
  logic [ADDR_W-1:0]          r_addr;     // address of the outstanding miss
  logic [WORD_W-1:0]          r_cpu_instr;
  logic                       r_cpu_valid;
  logic                       r_mem_req;
  logic [ADDR_W-OFF_W-1:0]    r_mem_addr;
  logic [CNT_W-1:0]           r_hit_cnt, r_miss_cnt;

  // lookup fields come from the live request, fill fields from the latched miss
  logic [OFF_W-1:0]           w_off, w_f_off;
  logic [IDX_W-1:0]           w_idx, w_f_idx;
  logic [TAG_W-1:0]           w_tag, w_f_tag;
  logic [1:0]                 w_way_hit;
  logic                       w_hit_way, w_victim;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] w_hit_words, w_fill_words;
  logic                       w_hit_go, w_miss_go, w_fill;

  assign w_off   = bus.cpu_addr[OFF_W-1:0];
  assign w_idx   = bus.cpu_addr[OFF_W +: IDX_W];
  assign w_tag   = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_f_off = r_addr[OFF_W-1:0];
  assign w_f_idx = r_addr[OFF_W +: IDX_W];
  assign w_f_tag = r_addr[ADDR_W-1 -: TAG_W];

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign w_way_hit[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
  end

  // way0 wins if both ways ever match
  assign w_hit_way    = ~w_way_hit[0];
  assign w_hit_words  = r_data[w_hit_way][w_idx];
  assign w_fill_words = bus.mem_line;

  // fill empty ways first, otherwise evict the LRU way
  assign w_victim = !r_valid[0][w_f_idx] ? 1'b0 :
                    !r_valid[1][w_f_idx] ? 1'b1 : r_lru[w_f_idx];

  // next state and per-cycle control; a flush alongside a request forces a miss
  always_comb begin
    w_state_nx = r_state;
    w_hit_go   = 1'b0;
    w_miss_go  = 1'b0;
    w_fill     = 1'b0;
    case (r_state)
      S_IDLE: if (bus.cpu_req) begin
        if (!bus.flush && (|w_way_hit)) begin
          w_hit_go = 1'b1;
        end else begin
          w_miss_go  = 1'b1;
          w_state_nx = S_FETCH;
        end
      end
      S_FETCH: if (bus.mem_valid) begin
        w_fill     = 1'b1;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // response, memory request and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_instr <= '0;
      r_cpu_valid <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_addr      <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_cpu_valid <= w_hit_go | w_fill;
      if (w_hit_go)    r_cpu_instr <= w_hit_words[w_off];
      else if (w_fill) r_cpu_instr <= w_fill_words[w_f_off];
      if (w_miss_go) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= bus.cpu_addr[ADDR_W-1:OFF_W];
        r_addr     <= bus.cpu_addr;
      end else if (w_fill) begin
        r_mem_req  <= 1'b0;
      end
      if (w_hit_go  && (r_hit_cnt  != '1)) r_hit_cnt  <= r_hit_cnt + 1'b1;
      if (w_miss_go && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  // valid/LRU bits; a refill landing with a flush still installs its line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_lru   <= '0;
    end else begin
      if (bus.flush) begin
        r_valid <= '0;
        r_lru   <= '0;
      end
      if (w_hit_go) r_lru[w_idx] <= ~w_hit_way;
      if (w_fill) begin
        r_valid[w_victim][w_f_idx] <= 1'b1;
        r_lru[w_f_idx]             <= ~w_victim;
      end
    end
  end

  // tag and data arrays: no reset, written only on refill
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_victim][w_f_idx]  <= w_f_tag;
      r_data[w_victim][w_f_idx] <= bus.mem_line;
    end
  end

  assign bus.cpu_instr = r_cpu_instr;
  assign bus.cpu_valid = r_cpu_valid;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.hit_cnt   = r_hit_cnt;
  assign bus.miss_cnt  = r_miss_cnt;
endmodule
